// File: rtl/pifo_reg_ctrl.sv
// pifo_reg_ctrl: turns an enqueue stream into register-PIFO insert/remove strobes and prefetches the PIFO min into a one-entry dequeue register.
// Latency: enq-to-deq 3 cycles through the PIFO (1 cycle on an empty PIFO when PIFO_BYPASS_EN is defined); at most one command every 2 cycles.
// Backpressure: enq_ready is low while a command settles or a flush runs; a stalled dequeue register blocks PIFO pops.
module pifo_reg_ctrl #(
  parameter int RANK_WIDTH   = 8,
  parameter int META_WIDTH   = 8,
  parameter int L2_REG_WIDTH = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [RANK_WIDTH-1:0]   enq_rank,
  input  logic [META_WIDTH-1:0]   enq_meta,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [RANK_WIDTH-1:0]   deq_rank,
  output logic [META_WIDTH-1:0]   deq_meta,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    pifo_insert,
  output logic                    pifo_remove,
  output logic [RANK_WIDTH-1:0]   pifo_rank_in,
  output logic [META_WIDTH-1:0]   pifo_meta_in,
  input  logic [RANK_WIDTH-1:0]   pifo_rank_out,
  input  logic [META_WIDTH-1:0]   pifo_meta_out,
  input  logic                    pifo_valid_out,
  input  logic [L2_REG_WIDTH:0]   pifo_num_entries,
  input  logic                    pifo_full,
  output logic [CNT_WIDTH-1:0]    overflow_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, FLUSH} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic                    run_q;
  logic                    vld_q;
  logic [RANK_WIDTH-1:0]   rank_q;
  logic [META_WIDTH-1:0]   meta_q;
  logic [CNT_WIDTH-1:0]    ovf_q;
  logic                    fdone_q;

  logic slot_free, is_idle, enq_acc, pop, byp;
  logic ins_d, rem_d, load_pifo, load_byp, clr_out, fdone_d;

  // run_q keeps enq_ready and the PIFO data bus at 0 until the first edge after reset
  assign slot_free = !vld_q || deq_ready;
  assign is_idle   = run_q && (state_q == IDLE);
  assign enq_ready = is_idle && !flush;
  assign enq_acc   = enq_valid && enq_ready;
  assign pop       = is_idle && pifo_valid_out && slot_free;

`ifdef PIFO_BYPASS_EN
  assign byp = enq_acc && (pifo_num_entries == '0) && !pifo_valid_out && slot_free;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ins_d     = 1'b0;
    rem_d     = 1'b0;
    load_pifo = 1'b0;
    load_byp  = 1'b0;
    clr_out   = 1'b0;
    fdone_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_q && flush) begin
          state_d = FLUSH;
          clr_out = 1'b1;
        end else if (byp) begin
          load_byp = 1'b1;
        end else if (enq_acc) begin
          ins_d = 1'b1;
          // a smaller incoming rank defers the pop so the new entry can win next time
          if (pop && (enq_rank >= pifo_rank_out)) begin
            rem_d     = 1'b1;
            load_pifo = 1'b1;
          end
        end else if (pop) begin
          rem_d     = 1'b1;
          load_pifo = 1'b1;
        end
        if (ins_d || rem_d) state_d = SETTLE;
      end
      SETTLE: begin
        if (flush) begin
          state_d = FLUSH;
          clr_out = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (pifo_num_entries != '0) begin
          rem_d = 1'b1;
        end else begin
          fdone_d = 1'b1;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      fdone_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      fdone_q <= fdone_d;
      if (ins_d && pifo_full && !rem_d && !(&ovf_q)) ovf_q <= ovf_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      rank_q <= '0;
      meta_q <= '0;
    end else if (clr_out) begin
      vld_q <= 1'b0;
    end else if (load_pifo) begin
      vld_q  <= 1'b1;
      rank_q <= pifo_rank_out;
      meta_q <= pifo_meta_out;
    end else if (load_byp) begin
      vld_q  <= 1'b1;
      rank_q <= enq_rank;
      meta_q <= enq_meta;
    end else if (deq_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign deq_valid    = vld_q;
  assign deq_rank     = rank_q;
  assign deq_meta     = meta_q;
  assign pifo_insert  = ins_d;
  assign pifo_remove  = rem_d;
  assign pifo_rank_in = run_q ? enq_rank : '0;
  assign pifo_meta_in = run_q ? enq_meta : '0;
  assign flush_done   = fdone_q;
  assign overflow_cnt = ovf_q;

endmodule
